text_buffer: RTL and testbench
==============================

TEXT_BUFFER -- requirements
Module: text_buffer

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning tile columns per row.
REQ-002 SHALL have parameter ROWS, default 30, meaning tile rows.
REQ-003 SHALL have parameter DATA_W, default 7, meaning tile code width in bits.
REQ-004 SHALL derive localparams COL_W = ceil(log2(COLS)) and ROW_W = ceil(log2(ROWS)).
REQ-005 SHALL have ports, in this order:
  clk_i      in   1       single clock; all logic on rising edge
  rst_i      in   1       synchronous reset, active-high
  wr_en_i    in   1       write strobe
  col_w_i    in   COL_W   write column (logical)
  row_w_i    in   ROW_W   write row (logical)
  din_i      in   DATA_W  write data
  col_r_i    in   COL_W   read column (logical)
  row_r_i    in   ROW_W   read row (logical)
  dout_o     out  DATA_W  read data
  clear_i    in   1       pulse: zero whole buffer
  scroll_i   in   1       pulse: scroll up one row
  busy_o     out  1       clear/scroll sequence in progress

Function
REQ-006 SHALL map logical to physical row as phys = (row + base) mod ROWS, for read and write; base is an internal ROW_W register.
REQ-007 SHALL return dout_o one cycle after col_r_i/row_r_i are presented (registered read).
REQ-008 SHALL be read-first: a read and write to the same tile in the same cycle returns the old value.
REQ-009 SHALL drop writes with col_w_i >= COLS or row_w_i >= ROWS; reads out of range SHALL return 0 one cycle later.
REQ-010 SHALL drive dout_o = 0 and ignore wr_en_i while busy_o = 1.
REQ-011 SHALL implement FSM states IDLE, CLR_ALL, CLR_ROW; busy_o = 1 in CLR_ALL and CLR_ROW.
REQ-012 SHALL in CLR_ALL write 0 to one physical tile per cycle in raster order from (0,0), taking exactly COLS*ROWS cycles, then go to IDLE and set base = 0.
REQ-013 SHALL on scroll_i in IDLE increment base modulo ROWS (ROWS-1 wraps to 0) and enter CLR_ROW.
REQ-014 SHALL in CLR_ROW zero the physical row that becomes logical row ROWS-1, one tile per cycle, COLS cycles, then go to IDLE.
REQ-015 SHALL accept clear_i in any state, restarting CLR_ALL from tile 0.
REQ-016 SHALL give clear_i priority over scroll_i when asserted together; scroll_i SHALL be ignored while busy_o = 1.
REQ-017 SHALL accept wr_en_i in the first IDLE cycle after busy_o falls.

Reset
REQ-018 SHALL on rst_i, in any state including mid-sequence, set base = 0, dout_o = 0, busy_o = 1 and enter CLR_ALL at tile 0.
REQ-019 SHALL not reset RAM storage directly; zeroing is done by CLR_ALL.

Configuration
REQ-020 SHALL compile scroll support only when TEXT_BUFFER_SCROLL_EN is defined.
REQ-021 SHALL without TEXT_BUFFER_SCROLL_EN ignore scroll_i, hold base = 0, and omit CLR_ROW; all other behaviour unchanged.

Structure
REQ-022 SHALL place default COLS/ROWS/DATA_W constants and the FSM state typedef in package text_buffer_pkg.
REQ-023 SHALL instantiate sub-module text_buffer_ram: simple dual-port, COLS*ROWS x DATA_W, one write port, one registered read port, read-first.

Verification
REQ-024 Reset, wait for busy_o low -> busy_o high exactly 2400 cycles (defaults); all 2400 reads then return 0.
REQ-025 Write 0,1,2,... raster from (0,0) to (79,29) modulo 2^7, read back raster -> dout_o equals written value, 1-cycle latency.
REQ-026 Write 5 to (3,2), read (3,2) same cycle -> old value 0; next read -> 5; write to (80,0) -> dropped, read (80,0) -> 0.
REQ-027 (TEXT_BUFFER_SCROLL_EN) Fill row r with value r, pulse scroll_i -> busy_o high 80 cycles; logical row r reads r+1 for r<29, row 29 reads 0; 30 scrolls return base to 0.
REQ-028 Pulse clear_i and scroll_i together mid-CLR_ROW -> CLR_ALL restarts, busy_o high 2400 cycles, base = 0.
REQ-029 Assert rst_i at cycle 1000 of CLR_ALL -> busy_o stays high 2400 further cycles; wr_en_i pulses during busy leave data 0.

Source files
------------

// File: rtl/text_buffer_pkg.sv
// Shared constants and FSM state type for the text tile buffer.
// Scroll support is built only when TEXT_BUFFER_SCROLL_EN is defined.
package text_buffer_pkg;

   localparam int COLS_DEF   = 80;
   localparam int ROWS_DEF   = 30;
   localparam int DATA_W_DEF = 7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CLR_ALL = 2'd1,
      CLR_ROW = 2'd2
   } state_t;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/text_buffer_ram.sv
// Simple dual-port tile storage: one write port, one registered
// read port, read-first on a same-address collision. No reset.
module text_buffer_ram #(
   parameter int DEPTH  = 2400,
   parameter int DATA_W = 7,
   parameter int ADDR_W = 12
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_q <= r_mem[i_raddr];
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/text_buffer.sv
// Tile text buffer with circular row base and clear/scroll sequencer.
// Optional scroll support: define TEXT_BUFFER_SCROLL_EN.
module text_buffer
   import text_buffer_pkg::*;
#(
   parameter int  COLS   = COLS_DEF,
   parameter int  ROWS   = ROWS_DEF,
   parameter int  DATA_W = DATA_W_DEF,
   localparam int COL_W  = clog2_min1(COLS),
   localparam int ROW_W  = clog2_min1(ROWS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_en_i,
   input  logic [COL_W-1:0]  col_w_i,
   input  logic [ROW_W-1:0]  row_w_i,
   input  logic [DATA_W-1:0] din_i,
   input  logic [COL_W-1:0]  col_r_i,
   input  logic [ROW_W-1:0]  row_r_i,
   output logic [DATA_W-1:0] dout_o,
   input  logic              clear_i,
   input  logic              scroll_i,
   output logic              busy_o
);

   localparam int DEPTH  = COLS * ROWS;
   localparam int ADDR_W = clog2_min1(DEPTH);

   localparam logic [ADDR_W-1:0] LAST_ALL = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
   localparam logic [COL_W:0]    COLS_X   = (COL_W+1)'(COLS);
   localparam logic [ROW_W:0]    ROWS_X   = (ROW_W+1)'(ROWS);

   state_t r_state;
   state_t w_next;

   logic [ADDR_W-1:0] r_cnt;
   logic [ROW_W-1:0]  w_base;
   logic              r_rd_ok;
   logic              w_busy;
   logic              w_restart;
   logic              w_wr_ok;
   logic              w_rd_ok;
   logic [ROW_W-1:0]  w_wphys;
   logic [ROW_W-1:0]  w_rphys;

   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_waddr;
   logic [ADDR_W-1:0] w_ram_raddr;
   logic [DATA_W-1:0] w_ram_wdata;
   logic [DATA_W-1:0] w_ram_q;

   function automatic logic [ROW_W-1:0] f_phys(
      input logic [ROW_W-1:0] row,
      input logic [ROW_W-1:0] base
   );
      logic [ROW_W:0] s;
      s = {1'b0, row} + {1'b0, base};
      if (s >= ROWS_X) begin
         s = s - ROWS_X;
      end
      return s[ROW_W-1:0];
   endfunction

   function automatic logic [ADDR_W-1:0] f_addr(
      input logic [ROW_W-1:0] row,
      input logic [COL_W-1:0] col
   );
      return ADDR_W'(row) * COLS_A + ADDR_W'(col);
   endfunction

`ifdef TEXT_BUFFER_SCROLL_EN
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(COLS - 1);
   localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(ROWS - 1);

   logic [ROW_W-1:0] r_base;
   logic [ROW_W-1:0] w_clr_row;

   assign w_base = r_base;
   // The row being zeroed is the one that just became logical ROWS-1.
   assign w_clr_row = (r_base == '0) ? ROW_MAX
                                     : r_base - ROW_W'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_base <= '0;
      end else if (r_state == CLR_ALL && w_next == IDLE) begin
         r_base <= '0;
      end else if (r_state == IDLE && w_next == CLR_ROW) begin
         r_base <= (r_base == ROW_MAX) ? '0
                                       : r_base + ROW_W'(1);
      end
   end
`else
   logic w_unused;

   assign w_base   = '0;
   assign w_unused = scroll_i;
`endif

   assign w_wphys = f_phys(row_w_i, w_base);
   assign w_rphys = f_phys(row_r_i, w_base);

   assign w_wr_ok = wr_en_i && !w_busy
                 && ({1'b0, col_w_i} < COLS_X)
                 && ({1'b0, row_w_i} < ROWS_X);

   assign w_rd_ok = ({1'b0, col_r_i} < COLS_X)
                 && ({1'b0, row_r_i} < ROWS_X);

   assign w_ram_raddr = w_rd_ok ? f_addr(w_rphys, col_r_i) : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= CLR_ALL;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (clear_i) begin
         w_next = CLR_ALL;
      end else begin
         case (r_state)
            IDLE: begin
`ifdef TEXT_BUFFER_SCROLL_EN
               if (scroll_i) begin
                  w_next = CLR_ROW;
               end
`endif
            end
            CLR_ALL: begin
               if (r_cnt == LAST_ALL) begin
                  w_next = IDLE;
               end
            end
`ifdef TEXT_BUFFER_SCROLL_EN
            CLR_ROW: begin
               if (r_cnt == LAST_ROW) begin
                  w_next = IDLE;
               end
            end
`endif
            default: w_next = IDLE;
         endcase
      end
   end

   always_comb begin
      w_busy      = (r_state != IDLE);
      w_ram_we    = w_wr_ok;
      w_ram_waddr = f_addr(w_wphys, col_w_i);
      w_ram_wdata = din_i;
      case (r_state)
         CLR_ALL: begin
            w_ram_we    = 1'b1;
            w_ram_waddr = r_cnt;
            w_ram_wdata = '0;
         end
`ifdef TEXT_BUFFER_SCROLL_EN
         CLR_ROW: begin
            w_ram_we    = 1'b1;
            w_ram_waddr = f_addr(w_clr_row, COL_W'(r_cnt));
            w_ram_wdata = '0;
         end
`endif
         default: ;
      endcase
   end

   assign w_restart = clear_i || (w_next != r_state);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt   <= '0;
         r_rd_ok <= 1'b0;
      end else begin
         if (w_restart) begin
            r_cnt <= '0;
         end else if (w_busy) begin
            r_cnt <= r_cnt + ADDR_W'(1);
         end
         // Reads issued during a sequence return 0 as well.
         r_rd_ok <= w_rd_ok && !w_busy;
      end
   end

   text_buffer_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_clk   (clk_i),
      .i_we    (w_ram_we),
      .i_waddr (w_ram_waddr),
      .i_wdata (w_ram_wdata),
      .i_raddr (w_ram_raddr),
      .o_rdata (w_ram_q)
   );

   assign busy_o = w_busy;
   assign dout_o = (r_rd_ok && !w_busy) ? w_ram_q : '0;

endmodule

// File: tb/tb_text_buffer.sv
// Directed bench for text_buffer (default 80x30x7 geometry).
// Scroll steps are compiled in when TEXT_BUFFER_SCROLL_EN is defined.
module tb_text_buffer;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       wr_en_i;
   logic [6:0] col_w_i;
   logic [4:0] row_w_i;
   logic [6:0] din_i;
   logic [6:0] col_r_i;
   logic [4:0] row_r_i;
   logic [6:0] dout_o;
   logic       clear_i;
   logic       scroll_i;
   logic       busy_o;

   int vecs = 0;
   int errs = 0;
   int n;

   always #5 clk_i = ~clk_i;

   text_buffer dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .wr_en_i  (wr_en_i),
      .col_w_i  (col_w_i),
      .row_w_i  (row_w_i),
      .din_i    (din_i),
      .col_r_i  (col_r_i),
      .row_r_i  (row_r_i),
      .dout_o   (dout_o),
      .clear_i  (clear_i),
      .scroll_i (scroll_i),
      .busy_o   (busy_o)
   );

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d",
                tag, obs, exp);
      end
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (busy_o !== 1'b0 && cnt < 5000) begin
         tick();
         cnt++;
      end
   endtask

   task automatic wr(input int c, input int r, input int d);
      wr_en_i = 1'b1;
      col_w_i = 7'(c);
      row_w_i = 5'(r);
      din_i   = 7'(d);
      tick();
      wr_en_i = 1'b0;
   endtask

   task automatic rd_check(input string tag, input int c,
                           input int r, input int exp);
      col_r_i = 7'(c);
      row_r_i = 5'(r);
      tick();
      check(tag, 32'(dout_o), 32'(exp));
   endtask

   task automatic pulse_clear;
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
   endtask

   initial begin
      rst_i    = 1'b1;
      wr_en_i  = 1'b0;
      col_w_i  = '0;
      row_w_i  = '0;
      din_i    = '0;
      col_r_i  = '0;
      row_r_i  = '0;
      clear_i  = 1'b0;
      scroll_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
      check("rst_busy", 32'(busy_o), 1);
      check("rst_dout", 32'(dout_o), 0);
      wait_idle(n);
      check("rst_len", n, 2400);

      for (int r = 0; r < 30; r++)
         for (int c = 0; c < 80; c++)
            rd_check("zero_sweep", c, r, 0);

      for (int r = 0; r < 30; r++)
         for (int c = 0; c < 80; c++)
            wr(c, r, (r * 80 + c) % 128);
      for (int r = 0; r < 30; r++)
         for (int c = 0; c < 80; c++)
            rd_check("raster", c, r, (r * 80 + c) % 128);

      // (79,29) holds 95; busy must mask it
      pulse_clear();
      check("clr_busy", 32'(busy_o), 1);
      check("busy_dout", 32'(dout_o), 0);
      wait_idle(n);
      check("clr_len", n, 2400);
      rd_check("clr_data", 79, 29, 0);

      wr_en_i = 1'b1;
      col_w_i = 7'd3;
      row_w_i = 5'd2;
      din_i   = 7'd5;
      col_r_i = 7'd3;
      row_r_i = 5'd2;
      tick();
      wr_en_i = 1'b0;
      check("read_first_old", 32'(dout_o), 0);
      tick();
      check("read_first_new", 32'(dout_o), 5);

      wr(80, 0, 9);
      rd_check("oor_col_rd", 80, 0, 0);
      rd_check("oor_col_alias", 0, 1, 0);
      wr(0, 30, 9);
      wr(0, 31, 9);
      rd_check("oor_row_rd", 5, 31, 0);
      rd_check("oor_row_r0", 0, 0, 0);
      rd_check("oor_row_r29", 0, 29, 0);
      rd_check("keep_32", 3, 2, 5);

      pulse_clear();
      for (int i = 0; i < 100; i++) begin
         wr_en_i = 1'b1;
         col_w_i = 7'd1;
         row_w_i = 5'd1;
         din_i   = 7'd7;
         tick();
      end
      wr_en_i = 1'b0;
      wait_idle(n);
      check("clr_len_wr", n, 2300);
      wr(4, 4, 11);
      rd_check("first_idle_wr", 4, 4, 11);
      rd_check("busy_wr_drop", 1, 1, 0);
      rd_check("clr_32", 3, 2, 0);

      pulse_clear();
      repeat (500) tick();
      pulse_clear();
      wait_idle(n);
      check("clr_restart", n, 2400);
      rd_check("clr_restart_d", 4, 4, 0);

      wr(2, 2, 6);
      pulse_clear();
      for (int i = 0; i < 1000; i++) begin
         wr_en_i = i[0];
         col_w_i = 7'd2;
         row_w_i = 5'd2;
         din_i   = 7'd9;
         tick();
      end
      wr_en_i = 1'b0;
      rst_i   = 1'b1;
      tick();
      rst_i = 1'b0;
      check("rst_mid_busy", 32'(busy_o), 1);
      check("rst_mid_dout", 32'(dout_o), 0);
      wait_idle(n);
      check("rst_mid_len", n, 2400);
      rd_check("rst_mid_data", 2, 2, 0);

      wr(6, 6, 13);
      clear_i  = 1'b1;
      scroll_i = 1'b1;
      tick();
      clear_i  = 1'b0;
      scroll_i = 1'b0;
      wait_idle(n);
      check("clr_prio_len", n, 2400);
      rd_check("clr_prio_d", 6, 6, 0);

`ifdef TEXT_BUFFER_SCROLL_EN
      for (int r = 0; r < 30; r++)
         for (int c = 0; c < 80; c++)
            wr(c, r, r);
      scroll_i = 1'b1;
      tick();
      scroll_i = 1'b0;
      check("scr_busy", 32'(busy_o), 1);
      wait_idle(n);
      check("scr_len", n, 80);
      for (int r = 0; r < 30; r++) begin
         rd_check("scr_c0", 0, r, (r < 29) ? r + 1 : 0);
         rd_check("scr_c79", 79, r, (r < 29) ? r + 1 : 0);
      end
      for (int k = 2; k <= 30; k++) begin
         scroll_i = 1'b1;
         tick();
         scroll_i = 1'b0;
         wait_idle(n);
         check("scr_k_len", n, 80);
         rd_check("scr_k_row0", 0, 0, (k < 30) ? k : 0);
         rd_check("scr_k_row29", 40, 29, 0);
      end

      for (int c = 0; c < 80; c++)
         wr(c, 1, 21);
      scroll_i = 1'b1;
      tick();
      repeat (10) tick();
      scroll_i = 1'b0;
      wait_idle(n);
      check("scr_ign_len", n, 70);
      tick();
      check("scr_ign_busy", 32'(busy_o), 0);
      rd_check("scr_ign_data", 7, 0, 21);

      wr(4, 4, 11);
      scroll_i = 1'b1;
      tick();
      scroll_i = 1'b0;
      repeat (10) tick();
      clear_i  = 1'b1;
      scroll_i = 1'b1;
      tick();
      clear_i  = 1'b0;
      scroll_i = 1'b0;
      wait_idle(n);
      check("row_clr_len", n, 2400);
      rd_check("row_clr_d", 4, 3, 0);
      wr(9, 0, 17);
      rd_check("row_clr_map", 9, 0, 17);
`else
      wr(0, 0, 3);
      scroll_i = 1'b1;
      tick();
      scroll_i = 1'b0;
      check("noscr_busy", 32'(busy_o), 0);
      rd_check("noscr_r0", 0, 0, 3);
      rd_check("noscr_r29", 0, 29, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vecs, errs);
      $finish;
   end

endmodule
